ca_rule_sequencer: RTL
======================

# ca_rule_sequencer

Cell-serial elementary cellular-automaton sequencer that time-shares one external 3-input logic function (a Wolfram-rule truth-table module) across a ring of WIDTH cells. It loads a seed row, presents each cell's {left, center, right} neighbourhood to the function one cell per cycle, and builds the next generation. It repeats this for a requested number of generations, then reports completion. It sits between a host or testbench and the combinational rule block, acting as that block's only driver.

## Interface
- WIDTH, 16, number of cells in the ring (≥3)
- CNT_W, 8, width of the generation counter and steps input
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE without done
- seed  in  WIDTH  initial row; captured on accepted start
- steps  in  CNT_W  generations to compute; captured on accepted start
- nbr  out  3  neighbourhood {in1,in2,in3} driven to the rule function
- rule_out  in  1  combinational rule result for nbr, sampled the same cycle
- row  out  WIDTH  current generation; bit i is cell i
- gen  out  CNT_W  generations completed in the current run
- busy  out  1  high whenever the FSM is not IDLE
- done  out  1  one-cycle completion pulse

## Operation
- Reset values: row=0, gen=0, busy=0, done=0, nbr=0, idx=0, state=IDLE.
- Neighbourhood of cell i is periodic:
  - in1 = row[(i+1) mod WIDTH] (left)
  - in2 = row[i]
  - in3 = row[(i−1) mod WIDTH] (right)
- States:
  - **IDLE**: on start=1, latch seed into row, latch steps, clear gen and idx. Go to DONE if steps=0, else go to EVAL.
  - **EVAL**: present nbr for cell idx from the unmodified row, and write next[idx] ← rule_out. row is not updated mid-generation. When idx=WIDTH−1:
    - row ← next, including the final bit from this cycle;
    - gen ← gen+1;
    - idx ← 0;
    - if gen+1 = captured steps, go to DONE, else stay in EVAL.
  - **DONE**: done=1 for exactly this cycle, then go to IDLE.
- nbr = 3'b000 outside EVAL.
- start is ignored while busy; steps and seed changes during a run have no effect.
- abort=1 in EVAL or DONE goes to IDLE next cycle with no done pulse; row and gen hold their last committed values. abort has priority over generation completion. abort in IDLE is a no-op; start is ignored in a cycle where abort=1.
- rst mid-run forces all outputs to their reset values immediately.
- gen counts modulo 2^CNT_W. steps is compared as unsigned, so steps = 2^CNT_W−1 is a legal maximum.

## Timing
- Start accepted at cycle 0 (IDLE, start=1).
- EVAL occupies cycles 1 … steps·WIDTH; cell idx of generation g is evaluated at cycle g·WIDTH + idx + 1.
- row and gen update on the clock edge ending each generation's last EVAL cycle.
- done is high at cycle steps·WIDTH + 1; busy falls the cycle after.
- steps=0: done at cycle 1 and row = seed.
- busy is high from cycle 1 through the done cycle inclusive.
- A new start is accepted the first cycle after returning to IDLE; there is no back-to-back start in the done cycle.

## Test plan
All scenarios use WIDTH=8 and a rule model with outputs of 1 only at 010, 100 and 101.

- **Single generation**: seed=0x01, steps=1 → nbr sequence 010,001,000×5,100 over cycles 1–8; row=0x81 and gen=1 after cycle 8; done at cycle 9.
- **Two generations**: seed=0x01, steps=2 → row=0x81 after cycle 8, row=0x40 after cycle 16; done at cycle 17; gen=2.
- **Zero steps and fixed point**:
  - seed=0xA5, steps=0 → done at cycle 1, row=0xA5, gen=0, no EVAL cycles.
  - seed=0x00, steps=5 → row stays 0x00; done at cycle 41.
- **Abort and busy start**:
  - seed=0x01, steps=3, abort at cycle 12 → IDLE at cycle 13, no done, row=0x81, gen=1.
  - start pulses at cycles 3 and 20 of a steps=3 run → both ignored; run completes normally at cycle 25.
- **Asynchronous reset**: assert rst mid-EVAL between clock edges → row, gen, busy, done and nbr go to 0 immediately. A start after rst deasserts runs correctly from cycle 0.

Source files
------------

// File: rtl/ca_rule_sequencer.sv
// ca_rule_sequencer
// -----------------
// Cell-serial elementary cellular-automaton engine. One external combinational
// rule block (a 3-input Wolfram truth table) is time-shared across a ring of
// WIDTH cells. The engine evaluates one cell per cycle and builds the next
// generation without disturbing the current one. It repeats this for the
// requested number of generations and then pulses o_done.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst       asynchronous, active-high reset
//   i_start     begin a run (sampled only in IDLE, ignored when i_abort=1)
//   i_abort     synchronous cancel from EVAL/DONE back to IDLE, no done pulse
//   i_seed      initial row, captured on an accepted start
//   i_steps     number of generations, captured on an accepted start
//   o_nbr       {left, center, right} neighbourhood driven to the rule block
//   i_rule_out  rule block result for o_nbr, sampled in the same cycle
//   o_row       current committed generation (bit i is cell i)
//   o_gen       generations completed in the current run (wraps mod 2^CNT_W)
//   o_busy      high whenever the FSM is not IDLE
//   o_done      one-cycle completion pulse
//   o_state     debug view of the FSM state (0 IDLE, 1 EVAL, 2 DONE)
//
// Handshake: the host raises i_start for one or more cycles while o_busy=0; the
// first such cycle with i_abort=0 is accepted. The run ends either with
// exactly one o_done cycle or, after i_abort, with o_busy falling and no done.

module ca_rule_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [CNT_W-1:0] i_steps,
  output logic [2:0]       o_nbr,
  input  logic             i_rule_out,
  output logic [WIDTH-1:0] o_row,
  output logic [CNT_W-1:0] o_gen,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_row;    // committed generation
  logic [WIDTH-1:0] r_next;   // next generation under construction
  logic [CNT_W-1:0] r_steps;
  logic [CNT_W-1:0] r_gen;
  logic [IDX_W-1:0] r_idx;

  logic [IDX_W-1:0] w_left_idx;
  logic [IDX_W-1:0] w_right_idx;
  logic [WIDTH-1:0] w_next_row;
  logic [CNT_W-1:0] w_gen_inc;
  logic             w_last;
  logic             w_accept;

  // Periodic neighbours: left is the higher index, right the lower one.
  assign w_left_idx  = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
  assign w_right_idx = (r_idx == '0) ? LAST_IDX : r_idx - IDX_W'(1);
  assign w_last      = (r_idx == LAST_IDX);
  assign w_gen_inc   = r_gen + CNT_W'(1);
  assign w_accept    = i_start && !i_abort;

  // Partial next row with this cycle's result merged in, so the final cell of
  // a generation can be committed together with the rest on the same edge.
  always_comb begin
    w_next_row        = r_next;
    w_next_row[r_idx] = i_rule_out;
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (i_steps == '0) ? S_DONE : S_EVAL;
        end
      end
      S_EVAL: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last && (w_gen_inc == r_steps)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row   <= '0;
      r_next  <= '0;
      r_steps <= '0;
      r_gen   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_row   <= i_seed;
            r_next  <= '0;
            r_steps <= i_steps;
            r_gen   <= '0;
            r_idx   <= '0;
          end
        end
        S_EVAL: begin
          // An abort leaves the last committed row and count untouched.
          if (!i_abort) begin
            r_next <= w_next_row;
            if (w_last) begin
              r_row <= w_next_row;
              r_gen <= w_gen_inc;
              r_idx <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_nbr = 3'b000;
    if (r_state == S_EVAL) begin
      o_nbr = {r_row[w_left_idx], r_row[r_idx], r_row[w_right_idx]};
    end
  end

  assign o_row   = r_row;
  assign o_gen   = r_gen;
  assign o_busy  = (r_state != S_IDLE);
  // An abort arriving in the DONE cycle suppresses the pulse.
  assign o_done  = (r_state == S_DONE) && !i_abort;
  assign o_state = r_state;

endmodule
